// File: rtl/pin_verification.sv
// PIN check stage: compares captured switch guesses against the stored PIN,
// counts failed attempts and holds a timed lockout after the last failure.
module pin_verification #(
    parameter int unsigned MAX_ATTEMPTS   = 3,
    parameter int unsigned LOCKOUT_CYCLES = 50_000_000,
    parameter int unsigned CNT_W          = 2
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Config_Done,
    input  logic [3:0]       A_Pin,
    input  logic [2:0]       B_Pin,
    input  logic             Enter,
    input  logic [3:0]       Switches_A_Guess,
    input  logic [2:0]       Switches_B_Guess,
    output logic             Unlocked,
    output logic             Denied,
    output logic             Locked_Out,
    output logic [CNT_W-1:0] Attempts_Left,
    output logic [2:0]       State_Code
);

    localparam int unsigned TIMER_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   ATTEMPTS_MAX = CNT_W'(MAX_ATTEMPTS);
    localparam logic [TIMER_W-1:0] TIMER_LOAD   = TIMER_W'(LOCKOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        READY    = 3'd1,
        CHECK    = 3'd2,
        UNLOCKED = 3'd3,
        LOCKOUT  = 3'd4
    } state_t;

    state_t             state, state_nxt;
    logic               enter_old;
    logic               enter_rise;
    logic [3:0]         guess_a, guess_a_nxt;
    logic [2:0]         guess_b, guess_b_nxt;
    logic [TIMER_W-1:0] timer, timer_nxt;
    logic [CNT_W-1:0]   attempts, attempts_nxt, attempts_dec;
    logic               denied_nxt;
    logic               guess_ok;

    assign enter_rise   = Enter & ~enter_old;
    assign guess_ok     = (guess_a == A_Pin) && (guess_b == B_Pin);
    // saturating decrement keeps the counter from wrapping below zero
    assign attempts_dec = (attempts != '0) ? (attempts - CNT_W'(1)) : '0;

    always_comb begin
        state_nxt    = state;
        attempts_nxt = attempts;
        timer_nxt    = timer;
        guess_a_nxt  = guess_a;
        guess_b_nxt  = guess_b;
        denied_nxt   = 1'b0;

        // losing the stored PIN abandons whatever is in progress
        if ((state != IDLE) && !Config_Done) begin
            state_nxt    = IDLE;
            attempts_nxt = ATTEMPTS_MAX;
            timer_nxt    = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Config_Done) begin
                        state_nxt    = READY;
                        attempts_nxt = ATTEMPTS_MAX;
                    end
                end
                READY: begin
                    if (enter_rise) begin
                        guess_a_nxt = Switches_A_Guess;
                        guess_b_nxt = Switches_B_Guess;
                        state_nxt   = CHECK;
                    end
                end
                CHECK: begin
                    if (guess_ok) begin
                        state_nxt    = UNLOCKED;
                        attempts_nxt = ATTEMPTS_MAX;
                    end else begin
                        denied_nxt   = 1'b1;
                        attempts_nxt = attempts_dec;
                        if (attempts_dec == '0) begin
                            state_nxt = LOCKOUT;
                            timer_nxt = TIMER_LOAD;
                        end else begin
                            state_nxt = READY;
                        end
                    end
                end
                UNLOCKED: begin
                    if (enter_rise) begin
                        state_nxt = READY;
                    end
                end
                LOCKOUT: begin
                    if (timer == '0) begin
                        state_nxt    = READY;
                        attempts_nxt = ATTEMPTS_MAX;
                    end else begin
                        timer_nxt = timer - TIMER_W'(1);
                    end
                end
                default: begin
                    state_nxt    = IDLE;
                    attempts_nxt = ATTEMPTS_MAX;
                    timer_nxt    = '0;
                end
            endcase
        end
    end

    // status flags are registered from the next state so they line up with State_Code
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            enter_old  <= 1'b0;
            guess_a    <= '0;
            guess_b    <= '0;
            timer      <= '0;
            attempts   <= ATTEMPTS_MAX;
            Unlocked   <= 1'b0;
            Denied     <= 1'b0;
            Locked_Out <= 1'b0;
        end else begin
            state      <= state_nxt;
            enter_old  <= Enter;
            guess_a    <= guess_a_nxt;
            guess_b    <= guess_b_nxt;
            timer      <= timer_nxt;
            attempts   <= attempts_nxt;
            Unlocked   <= (state_nxt == UNLOCKED);
            Denied     <= denied_nxt;
            Locked_Out <= (state_nxt == LOCKOUT);
        end
    end

    assign Attempts_Left = attempts;
    assign State_Code    = state;

endmodule

// File: tb/tb_pin_verification.sv
// Bench for pin_verification: directed scenarios followed by random traffic,
// all checked every cycle against a behavioural model of the PIN checker.
module tb_pin_verification;

    localparam int unsigned MAXA = 3;
    localparam int unsigned LOCK = 10;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       Config_Done;
    logic [3:0] A_Pin;
    logic [2:0] B_Pin;
    logic       Enter;
    logic [3:0] Switches_A_Guess;
    logic [2:0] Switches_B_Guess;
    logic       Unlocked;
    logic       Denied;
    logic       Locked_Out;
    logic [1:0] Attempts_Left;
    logic [2:0] State_Code;

    int n_checks = 0;
    int n_fail   = 0;

    // model of the checker's observable behaviour
    bit m_active, m_pending, m_unlocked, m_denied, m_prev;
    int m_lock_left, m_attempts, m_ga, m_gb;

    pin_verification #(
        .MAX_ATTEMPTS  (MAXA),
        .LOCKOUT_CYCLES(LOCK),
        .CNT_W         (2)
    ) dut (
        .Clk             (Clk),
        .Reset_n         (Reset_n),
        .Config_Done     (Config_Done),
        .A_Pin           (A_Pin),
        .B_Pin           (B_Pin),
        .Enter           (Enter),
        .Switches_A_Guess(Switches_A_Guess),
        .Switches_B_Guess(Switches_B_Guess),
        .Unlocked        (Unlocked),
        .Denied          (Denied),
        .Locked_Out      (Locked_Out),
        .Attempts_Left   (Attempts_Left),
        .State_Code      (State_Code)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active    = 0;
        m_pending   = 0;
        m_unlocked  = 0;
        m_denied    = 0;
        m_prev      = 0;
        m_lock_left = 0;
        m_attempts  = MAXA;
        m_ga        = 0;
        m_gb        = 0;
    endtask

    // advance the model by one rising edge using the inputs now applied
    task automatic model_step();
        bit rise;
        rise     = Enter && !m_prev;
        m_prev   = Enter;
        m_denied = 0;
        if (!m_active) begin
            if (Config_Done) begin
                m_active   = 1;
                m_attempts = MAXA;
            end
        end else if (!Config_Done) begin
            m_active    = 0;
            m_pending   = 0;
            m_unlocked  = 0;
            m_lock_left = 0;
            m_attempts  = MAXA;
        end else if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) m_attempts = MAXA;
        end else if (m_pending) begin
            m_pending = 0;
            if (m_ga == int'(A_Pin) && m_gb == int'(B_Pin)) begin
                m_unlocked = 1;
                m_attempts = MAXA;
            end else begin
                m_denied = 1;
                if (m_attempts > 0) m_attempts--;
                if (m_attempts == 0) m_lock_left = LOCK;
            end
        end else if (m_unlocked) begin
            if (rise) m_unlocked = 0;
        end else if (rise) begin
            m_pending = 1;
            m_ga      = int'(Switches_A_Guess);
            m_gb      = int'(Switches_B_Guess);
        end
    endtask

    function automatic int model_code();
        if (!m_active)            return 0;
        else if (m_pending)       return 2;
        else if (m_unlocked)      return 3;
        else if (m_lock_left > 0) return 4;
        else                      return 1;
    endfunction

    task automatic compare_all();
        check("unlocked",   Unlocked,      m_unlocked);
        check("denied",     Denied,        m_denied);
        check("locked_out", Locked_Out,    (m_lock_left > 0));
        check("attempts",   Attempts_Left, m_attempts);
        check("state_code", State_Code,    model_code());
    endtask

    task automatic cycle(input logic c, input logic e, input logic [3:0] ga, input logic [2:0] gb);
        Config_Done      = c;
        Enter            = e;
        Switches_A_Guess = ga;
        Switches_B_Guess = gb;
        model_step();
        @(posedge Clk);
        #1;
        compare_all();
    endtask

    task automatic wrong_guess();
        cycle(1'b1, 1'b1, 4'hA, 3'h4);
        cycle(1'b1, 1'b0, 4'h3, 3'h4);
    endtask

    initial begin
        int nd;
        int lc;
        Reset_n          = 1'b0;
        Config_Done      = 1'b0;
        A_Pin            = 4'hA;
        B_Pin            = 3'h5;
        Enter            = 1'b0;
        Switches_A_Guess = '0;
        Switches_B_Guess = '0;
        model_reset();
        repeat (2) @(negedge Clk);
        compare_all();
        check("rst_attempts", Attempts_Left, 3);
        Reset_n = 1'b1;

        // correct guess unlocks two edges after the Enter rise
        cycle(1'b1, 1'b0, 4'h0, 3'h0);
        check("t1_ready", State_Code, 1);
        cycle(1'b1, 1'b1, 4'hA, 3'h5);
        check("t1_check", State_Code, 2);
        check("t1_not_yet", Unlocked, 0);
        cycle(1'b1, 1'b0, 4'h1, 3'h1);
        check("t1_unlocked", Unlocked, 1);
        check("t1_attempts", Attempts_Left, 3);

        // relock from UNLOCKED
        cycle(1'b1, 1'b1, 4'h0, 3'h0);
        check("t5_relock_state", State_Code, 1);
        check("t5_relock_unl", Unlocked, 0);
        cycle(1'b1, 1'b0, 4'h0, 3'h0);

        // B field wrong only
        wrong_guess();
        check("t2_denied", Denied, 1);
        check("t2_attempts", Attempts_Left, 2);
        check("t2_unlocked", Unlocked, 0);
        cycle(1'b1, 1'b0, 4'h0, 3'h0);
        check("t2_denied_gone", Denied, 0);
        check("t2_ready", State_Code, 1);

        // held Enter gives a single event
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b1, 4'hA, 3'h4);
            if (Denied) nd++;
        end
        check("t4_denied_count", nd, 1);
        check("t4_attempts", Attempts_Left, 1);
        cycle(1'b1, 1'b0, 4'h0, 3'h0);

        // dropping Config_Done returns to IDLE and Enter is ignored there
        cycle(1'b0, 1'b0, 4'h0, 3'h0);
        check("t5_idle", State_Code, 0);
        check("t5_idle_attempts", Attempts_Left, 3);
        cycle(1'b0, 1'b1, 4'hA, 3'h5);
        cycle(1'b0, 1'b0, 4'hA, 3'h5);
        cycle(1'b0, 1'b1, 4'hA, 3'h5);
        check("t5_idle_enter", State_Code, 0);
        cycle(1'b1, 1'b0, 4'h0, 3'h0);
        check("t5_back_ready", State_Code, 1);

        // three failures lead to a LOCK-cycle lockout
        repeat (3) wrong_guess();
        lc = Locked_Out ? 1 : 0;
        for (int i = 0; i < 30; i++) begin
            cycle(1'b1, (i < 8) ? logic'(i % 2) : 1'b0, 4'hA, 3'h5);
            if (Locked_Out) lc++;
        end
        check("t3_lock_cycles", lc, LOCK);
        check("t3_ready", State_Code, 1);
        check("t3_attempts", Attempts_Left, 3);

        // asynchronous reset in the middle of a lockout
        repeat (3) wrong_guess();
        repeat (3) cycle(1'b1, 1'b0, 4'h0, 3'h0);
        check("t6_in_lockout", Locked_Out, 1);
        #2 Reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("t6_locked", Locked_Out, 0);
        check("t6_state", State_Code, 0);
        @(negedge Clk);
        Reset_n = 1'b1;

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic       c, e;
            logic [3:0] ga;
            logic [2:0] gb;
            if ($urandom_range(0, 299) == 0) begin
                A_Pin = 4'($urandom);
                B_Pin = 3'($urandom);
            end
            c = ($urandom_range(0, 99) != 0);
            e = ($urandom_range(0, 2) == 0) ? ~Enter : Enter;
            if ($urandom_range(0, 1) == 1) begin
                ga = A_Pin;
                gb = B_Pin;
            end else begin
                ga = 4'($urandom);
                gb = 3'($urandom);
            end
            cycle(c, e, ga, gb);
            if ($urandom_range(0, 499) == 0) begin
                #2 Reset_n = 1'b0;
                #1;
                model_reset();
                compare_all();
                @(negedge Clk);
                Reset_n = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
